ram_arbiter: RTL and testbench

Shares the single 512-byte RAM port between the instruction-fetch path (control unit fetch states) and the data load/store path. Uses the RAM's MFA/MFC handshake on both sides. Arbitrates round-robin between the two requesters, checks size and alignment, and aborts accesses the RAM never completes. Sits between the control unit/datapath and the RAM module, replacing the direct `ramMFA`/`ramAddress` wiring.

---
 rtl/ram_arb_pkg.sv | 37 +++
 rtl/ram_arb_timer.sv | 30 +++
 rtl/ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_arbiter.sv | 551 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the RAM port arbiter.
// FSM states, access size codes, port ids and the alignment rule.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic {
        PORT_F,
        PORT_D
    } port_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Reserved size code 2'b10 is never aligned.
    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [1:0] addr
    );
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr[0];
            SZ_WORD: ok = (addr == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ram_arb_timer.sv
// ram_arb_timer: access watchdog, counts ACCESS cycles.
// Ports: clk, rst_n, clr (grant), en (in ACCESS), expired (count hits TIMEOUT this edge).
module ram_arb_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // High in the cycle whose closing edge brings the count to TIMEOUT.
    assign expired = en && (cnt == CW'(TIMEOUT - 1));

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin share of the RAM port between fetch and data.
// Ports: f_*/d_* MFA/MFC requesters, ram_* RAM side, rdata shared read data.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned AW      = 9
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          f_mfa,
    input  logic          d_mfa,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] d_addr,
    input  logic          d_rw,
    input  logic [1:0]    f_size,
    input  logic [1:0]    d_size,
    input  logic [31:0]   d_wdata,
    output logic          f_mfc,
    output logic          d_mfc,
    output logic          f_err,
    output logic          d_err,
    output logic [31:0]   rdata,
    output logic          ram_mfa,
    output logic          ram_rw,
    output logic [1:0]    ram_size,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic          ram_mfc,
    input  logic [31:0]   ram_rdata
);

    state_t state;
    port_t  gnt;
    port_t  last;
    logic   blk_f;
    logic   blk_d;

    logic          f_el;
    logic          d_el;
    logic          pick_f;
    logic          take;
    logic          in_acc;
    logic          sel_ok;
    logic          expired;
    logic          fin_f;
    logic          fin_d;
    logic [AW-1:0] sel_addr;
    logic [1:0]    sel_size;
    logic          sel_rw;
    logic [31:0]   sel_wdata;

    always_comb begin
        f_el      = f_mfa & ~blk_f;
        d_el      = d_mfa & ~blk_d;
        // Tie goes to the port that did not win the previous grant.
        pick_f    = f_el & (~d_el | (last == PORT_D));
        take      = (state == ST_IDLE) & (f_el | d_el);
        in_acc    = (state == ST_ACCESS);
        sel_addr  = pick_f ? f_addr : d_addr;
        sel_size  = pick_f ? f_size : d_size;
        sel_rw    = pick_f ? 1'b0 : d_rw;
        sel_wdata = pick_f ? 32'h0 : d_wdata;
        sel_ok    = is_aligned(sel_size, sel_addr[1:0]);
        fin_f     = 1'b0;
        fin_d     = 1'b0;
        if (take && !sel_ok) begin
            fin_f = pick_f;
            fin_d = ~pick_f;
        end else if (in_acc && (ram_mfc || expired)) begin
            fin_f = (gnt == PORT_F);
            fin_d = (gnt == PORT_D);
        end
    end

    ram_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (Clk),
        .rst_n  (reset),
        .clr    (take),
        .en     (in_acc),
        .expired(expired)
    );

    always_ff @(negedge Clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            gnt       <= PORT_F;
            last      <= PORT_D;
            blk_f     <= 1'b0;
            blk_d     <= 1'b0;
            f_mfc     <= 1'b0;
            d_mfc     <= 1'b0;
            f_err     <= 1'b0;
            d_err     <= 1'b0;
            rdata     <= '0;
            ram_mfa   <= 1'b0;
            ram_rw    <= 1'b0;
            ram_size  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            f_mfc <= 1'b0;
            d_mfc <= 1'b0;
            f_err <= 1'b0;
            d_err <= 1'b0;
            // A finished port stays blocked until it drops its request.
            blk_f <= fin_f | (blk_f & f_mfa);
            blk_d <= fin_d | (blk_d & d_mfa);
            unique case (state)
                ST_IDLE: begin
                    if (take) begin
                        gnt       <= pick_f ? PORT_F : PORT_D;
                        last      <= pick_f ? PORT_F : PORT_D;
                        ram_addr  <= sel_addr;
                        ram_rw    <= sel_rw;
                        ram_size  <= sel_size;
                        ram_wdata <= sel_wdata;
                        if (sel_ok) begin
                            state   <= ST_ACCESS;
                            ram_mfa <= 1'b1;
                        end else begin
                            state <= ST_ERR;
                            f_mfc <= pick_f;
                            f_err <= pick_f;
                            d_mfc <= ~pick_f;
                            d_err <= ~pick_f;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Completion beats the watchdog on the same edge.
                    if (ram_mfc) begin
                        state   <= ST_DONE;
                        ram_mfa <= 1'b0;
                        if (!ram_rw) begin
                            rdata <= ram_rdata;
                        end
                        f_mfc <= (gnt == PORT_F);
                        d_mfc <= (gnt == PORT_D);
                    end else if (expired) begin
                        state   <= ST_ERR;
                        ram_mfa <= 1'b0;
                        f_mfc   <= (gnt == PORT_F);
                        f_err   <= (gnt == PORT_F);
                        d_mfc   <= (gnt == PORT_D);
                        d_err   <= (gnt == PORT_D);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter.
// A byte RAM model answers the RAM port; a transaction model predicts results.
module tb_ram_arbiter;

    localparam int TMO = 8;

    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_mfa = 1'b0;
    logic        d_mfa = 1'b0;
    logic [8:0]  f_addr = '0;
    logic [8:0]  d_addr = '0;
    logic        d_rw = 1'b0;
    logic [1:0]  f_size = '0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_wdata = '0;
    logic        f_mfc;
    logic        d_mfc;
    logic        f_err;
    logic        d_err;
    logic [31:0] rdata;
    logic        ram_mfa;
    logic        ram_rw;
    logic [1:0]  ram_size;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_mfc = 1'b0;
    logic [31:0] ram_rdata = '0;

    ram_arbiter #(
        .TIMEOUT(TMO),
        .AW     (9)
    ) dut (
        .Clk      (Clk),
        .reset    (reset),
        .f_mfa    (f_mfa),
        .d_mfa    (d_mfa),
        .f_addr   (f_addr),
        .d_addr   (d_addr),
        .d_rw     (d_rw),
        .f_size   (f_size),
        .d_size   (d_size),
        .d_wdata  (d_wdata),
        .f_mfc    (f_mfc),
        .d_mfc    (d_mfc),
        .f_err    (f_err),
        .d_err    (d_err),
        .rdata    (rdata),
        .ram_mfa  (ram_mfa),
        .ram_rw   (ram_rw),
        .ram_size (ram_size),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_mfc  (ram_mfc),
        .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [8:0]  a;
        logic        rw;
        logic [1:0]  s;
        logic [31:0] wd;
    } acc_t;

    int   total = 0;
    int   bad = 0;
    int   lat_cfg = 1;
    int   wcnt = 0;
    int   mfa_rises = 0;
    logic mfa_prev = 1'b0;
    logic [7:0] mem [512];
    logic [7:0] ref_mem [512];
    acc_t ram_q[$];
    acc_t exp_q[$];
    bit   m_last_d = 1'b1;
    logic [31:0] cur_rdata = '0;

    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 1;
        if (s == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal(input logic [1:0] s, input logic [8:0] a);
        int ai;
        ai = int'(a);
        case (s)
            2'b00:   return 1'b1;
            2'b01:   return (ai % 2) == 0;
            2'b11:   return (ai % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [8:0] a, input logic [1:0] s);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < nbytes(s); i++)
            v = v | (32'(ref_mem[(int'(a) + i) % 512]) << (8 * i));
        return v;
    endfunction

    function automatic void ref_write(input logic [8:0] a, input logic [1:0] s,
                                      input logic [31:0] w);
        for (int i = 0; i < nbytes(s); i++)
            ref_mem[(int'(a) + i) % 512] = 8'(w >> (8 * i));
    endfunction

    // RAM model: answers ram_mfa after lat_cfg cycles (0 = never).
    always @(posedge Clk) begin
        if (ram_mfa && !mfa_prev) mfa_rises++;
        mfa_prev = ram_mfa;
        if (ram_mfc) begin
            ram_mfc = 1'b0;
            wcnt = 0;
        end else if (ram_mfa) begin
            wcnt++;
            if (lat_cfg != 0 && wcnt == lat_cfg) begin
                ram_mfc = 1'b1;
                ram_q.push_back('{ram_addr, ram_rw, ram_size, ram_wdata});
                if (ram_rw) begin
                    ram_rdata = $urandom;
                    for (int i = 0; i < nbytes(ram_size); i++)
                        mem[(int'(ram_addr) + i) % 512] = 8'(ram_wdata >> (8 * i));
                end else begin
                    ram_rdata = '0;
                    for (int i = 0; i < nbytes(ram_size); i++)
                        ram_rdata = ram_rdata |
                            (32'(mem[(int'(ram_addr) + i) % 512]) << (8 * i));
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic do_round(input bit rf, input bit rd,
                            input logic [8:0] fa, input logic [1:0] fs,
                            input logic [8:0] da, input logic [1:0] ds,
                            input bit drw, input logic [31:0] dwd,
                            input int lat, input int tag);
        bit first_d, e_f, e_d, timed, got_f, got_d, seen, seen_d, pd;
        logic [31:0] r_f, r_d;
        int n_acc, rises0;
        acc_t ea, ga;
        timed = (lat == 0) || (lat > TMO);
        e_f = !legal(fs, fa) || timed;
        e_d = !legal(ds, da) || timed;
        first_d = (rf && rd) ? !m_last_d : rd;
        n_acc = 0;
        r_f = cur_rdata;
        r_d = cur_rdata;
        exp_q.delete();
        ram_q.delete();
        for (int s = 0; s < 2; s++) begin
            pd = (s == 0) ? first_d : !first_d;
            if (pd ? !rd : !rf) continue;
            if (!pd) begin
                if (legal(fs, fa)) n_acc++;
                if (!e_f) begin
                    cur_rdata = ref_read(fa, fs);
                    exp_q.push_back('{fa, 1'b0, fs, 32'h0});
                end
                r_f = cur_rdata;
            end else begin
                if (legal(ds, da)) n_acc++;
                if (!e_d) begin
                    if (drw) ref_write(da, ds, dwd);
                    else cur_rdata = ref_read(da, ds);
                    exp_q.push_back('{da, drw, ds, dwd});
                end
                r_d = cur_rdata;
            end
            m_last_d = pd;
        end
        lat_cfg = lat;
        got_f = !rf;
        got_d = !rd;
        seen = 1'b0;
        seen_d = 1'b0;
        @(posedge Clk);
        rises0 = mfa_rises;
        f_addr = fa; f_size = fs;
        d_addr = da; d_size = ds; d_rw = drw; d_wdata = dwd;
        f_mfa = rf;
        d_mfa = rd;
        for (int c = 0; c < 80 && !(got_f && got_d); c++) begin
            @(posedge Clk);
            if (f_mfc) begin
                total++;
                if (got_f) begin
                    bad++;
                    $display("FAIL r%0d f_dup: f_mfc=1 required none", tag);
                end
                total++;
                if (f_err !== e_f) begin
                    bad++;
                    $display("FAIL r%0d f_err: got %b required %b", tag, f_err, e_f);
                end
                total++;
                if (rdata !== r_f) begin
                    bad++;
                    $display("FAIL r%0d f_rdata: got %h required %h", tag, rdata, r_f);
                end
                if (!seen) begin seen = 1'b1; seen_d = 1'b0; end
                got_f = 1'b1;
                f_mfa = 1'b0;
            end
            if (d_mfc) begin
                total++;
                if (got_d) begin
                    bad++;
                    $display("FAIL r%0d d_dup: d_mfc=1 required none", tag);
                end
                total++;
                if (d_err !== e_d) begin
                    bad++;
                    $display("FAIL r%0d d_err: got %b required %b", tag, d_err, e_d);
                end
                total++;
                if (rdata !== r_d) begin
                    bad++;
                    $display("FAIL r%0d d_rdata: got %h required %h", tag, rdata, r_d);
                end
                if (!seen) begin seen = 1'b1; seen_d = 1'b1; end
                got_d = 1'b1;
                d_mfa = 1'b0;
            end
        end
        f_mfa = 1'b0;
        d_mfa = 1'b0;
        total++;
        if (!(got_f && got_d)) begin
            bad++;
            $display("FAIL r%0d done: got f=%b d=%b required both", tag, got_f, got_d);
        end
        if (rf && rd) begin
            total++;
            if (seen_d !== first_d) begin
                bad++;
                $display("FAIL r%0d order: first_d=%b required %b", tag, seen_d, first_d);
            end
        end
        @(posedge Clk);
        total++;
        if ({f_mfc, d_mfc, ram_mfa} !== 3'b000) begin
            bad++;
            $display("FAIL r%0d quiet: mfc/mfa=%b required 000", tag, {f_mfc, d_mfc, ram_mfa});
        end
        total++;
        if (mfa_rises - rises0 != n_acc) begin
            bad++;
            $display("FAIL r%0d rises: got %0d required %0d", tag, mfa_rises - rises0, n_acc);
        end
        total++;
        if (ram_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL r%0d ram_log: got %0d required %0d", tag, ram_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                ea = exp_q[i];
                ga = ram_q[i];
                total++;
                if (ga.a !== ea.a || ga.rw !== ea.rw || ga.s !== ea.s ||
                    (ea.rw && ga.wd !== ea.wd)) begin
                    bad++;
                    $display("FAIL r%0d ram_acc: got %h/%b/%b/%h required %h/%b/%b/%h",
                             tag, ga.a, ga.rw, ga.s, ga.wd, ea.a, ea.rw, ea.s, ea.wd);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge Clk);
        total++;
        if ({f_mfc, d_mfc, f_err, d_err, rdata, ram_mfa, ram_rw, ram_size,
             ram_addr, ram_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_hold: outputs nonzero required 0");
        end
        reset = 1'b1;
        repeat (2) @(posedge Clk);
        total++;
        if ({f_mfc, d_mfc, ram_mfa, rdata} !== '0) begin
            bad++;
            $display("FAIL reset_idle: outputs nonzero required 0");
        end
    endtask

    task automatic test_tie();
        do_round(1, 1, 9'h080, 2'b11, 9'h084, 2'b11, 0, 32'h0, 1, 100);
        do_round(1, 1, 9'h088, 2'b01, 9'h08c, 2'b11, 1, 32'hCAFE_F00D, 2, 101);
        do_round(1, 0, 9'h08c, 2'b11, 9'h000, 2'b00, 0, 32'h0, 1, 102);
        do_round(1, 1, 9'h090, 2'b00, 9'h08c, 2'b11, 0, 32'h0, 1, 103);
    endtask

    task automatic test_fetch_word();
        lat_cfg = 2;
        @(posedge Clk);
        f_addr = 9'h010; f_size = 2'b11; f_mfa = 1'b1;
        @(posedge Clk);
        total++;
        if ({ram_mfa, ram_rw, ram_size, ram_addr, f_mfc} !== {1'b1, 1'b0, 2'b11, 9'h010, 1'b0}) begin
            bad++;
            $display("FAIL fw_grant: mfa=%b rw=%b size=%b addr=%h required 1 0 11 010",
                     ram_mfa, ram_rw, ram_size, ram_addr);
        end
        @(posedge Clk);
        total++;
        if ({ram_mfa, f_mfc} !== 2'b10) begin
            bad++;
            $display("FAIL fw_wait: mfa/mfc=%b required 10", {ram_mfa, f_mfc});
        end
        @(posedge Clk);
        total++;
        if ({f_mfc, f_err, ram_mfa} !== 3'b100 || rdata !== 32'h8C22_0004) begin
            bad++;
            $display("FAIL fw_done: mfc/err/mfa=%b rdata=%h required 100 8c220004",
                     {f_mfc, f_err, ram_mfa}, rdata);
        end
        f_mfa = 1'b0;
        @(posedge Clk);
        total++;
        if (f_mfc !== 1'b0) begin
            bad++;
            $display("FAIL fw_pulse: f_mfc=%b required 0", f_mfc);
        end
        cur_rdata = 32'h8C22_0004;
        m_last_d = 1'b0;
    endtask

    task automatic test_errors();
        do_round(0, 1, 9'h0, 2'b0, 9'h101, 2'b01, 1, 32'h1234_5678, 1, 200);
        do_round(0, 1, 9'h0, 2'b0, 9'h100, 2'b10, 0, 32'h0, 1, 201);
        do_round(0, 1, 9'h0, 2'b0, 9'h101, 2'b00, 1, 32'h0000_00A5, 1, 202);
        do_round(0, 1, 9'h0, 2'b0, 9'h100, 2'b11, 0, 32'h0, 1, 203);
        do_round(1, 1, 9'h012, 2'b11, 9'h020, 2'b11, 0, 32'h0, 2, 204);
    endtask

    task automatic test_timeout();
        int lats [3] = '{0, 8, 9};
        int hi;
        bit got, okx;
        for (int i = 0; i < 3; i++) begin
            lat_cfg = lats[i];
            okx = (lats[i] == TMO);
            hi = 0;
            got = 1'b0;
            @(posedge Clk);
            f_addr = 9'h0a0; f_size = 2'b11; f_mfa = 1'b1;
            for (int c = 0; c < 40 && !got; c++) begin
                @(posedge Clk);
                if (ram_mfa) hi++;
                if (f_mfc) begin
                    got = 1'b1;
                    f_mfa = 1'b0;
                    if (okx) cur_rdata = ref_read(9'h0a0, 2'b11);
                    total++;
                    if (f_err !== !okx || rdata !== cur_rdata) begin
                        bad++;
                        $display("FAIL to%0d result: err=%b rdata=%h required %b %h",
                                 i, f_err, rdata, !okx, cur_rdata);
                    end
                end
            end
            f_mfa = 1'b0;
            m_last_d = 1'b0;
            total++;
            if (!got || hi != TMO) begin
                bad++;
                $display("FAIL to%0d mfa_cycles: got=%b high=%0d required 1 %0d", i, got, hi, TMO);
            end
            @(posedge Clk);
            total++;
            if ({f_mfc, ram_mfa} !== 2'b00) begin
                bad++;
                $display("FAIL to%0d after: mfc/mfa=%b required 00", i, {f_mfc, ram_mfa});
            end
        end
    endtask

    task automatic test_block();
        int nf, nd;
        bit got;
        lat_cfg = 1;
        @(posedge Clk);
        f_addr = 9'h031; f_size = 2'b00; f_mfa = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge Clk);
            if (f_mfc) got = 1'b1;
        end
        cur_rdata = ref_read(9'h031, 2'b00);
        total++;
        if (!got || rdata !== cur_rdata) begin
            bad++;
            $display("FAIL blk_first: got=%b rdata=%h required 1 %h", got, rdata, cur_rdata);
        end
        d_addr = 9'h042; d_size = 2'b01; d_rw = 1'b0; d_mfa = 1'b1;
        nf = 0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge Clk);
            if (f_mfc) nf++;
            if (d_mfc) begin
                nd++;
                d_mfa = 1'b0;
                total++;
                if (d_err !== 1'b0 || rdata !== ref_read(9'h042, 2'b01)) begin
                    bad++;
                    $display("FAIL blk_data: err=%b rdata=%h required 0 %h",
                             d_err, rdata, ref_read(9'h042, 2'b01));
                end
            end
        end
        cur_rdata = ref_read(9'h042, 2'b01);
        total++;
        if (nf != 0 || nd != 1) begin
            bad++;
            $display("FAIL blk_count: f=%0d d=%0d required 0 1", nf, nd);
        end
        f_mfa = 1'b0;
        @(posedge Clk);
        f_mfa = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge Clk);
            if (f_mfc) begin
                got = 1'b1;
                f_mfa = 1'b0;
            end
        end
        f_mfa = 1'b0;
        cur_rdata = ref_read(9'h031, 2'b00);
        m_last_d = 1'b0;
        total++;
        if (!got || f_err !== 1'b0 || rdata !== cur_rdata) begin
            bad++;
            $display("FAIL blk_again: got=%b err=%b rdata=%h required 1 0 %h",
                     got, f_err, rdata, cur_rdata);
        end
        @(posedge Clk);
    endtask

    task automatic test_reset_mid();
        int nf;
        bit got;
        lat_cfg = 0;
        @(posedge Clk);
        f_addr = 9'h040; f_size = 2'b11; f_mfa = 1'b1;
        @(posedge Clk);
        total++;
        if (ram_mfa !== 1'b1) begin
            bad++;
            $display("FAIL rm_access: ram_mfa=%b required 1", ram_mfa);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({f_mfc, d_mfc, f_err, d_err, rdata, ram_mfa, ram_rw, ram_size,
             ram_addr, ram_wdata} !== '0) begin
            bad++;
            $display("FAIL rm_async: outputs nonzero (mfa=%b addr=%h) required 0", ram_mfa, ram_addr);
        end
        nf = 0;
        repeat (2) begin
            @(posedge Clk);
            if (f_mfc || ram_mfa) nf++;
        end
        total++;
        if (nf != 0) begin
            bad++;
            $display("FAIL rm_quiet: active cycles=%0d required 0", nf);
        end
        m_last_d = 1'b1;
        cur_rdata = '0;
        lat_cfg = 1;
        reset = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge Clk);
            if (f_mfc) begin
                got = 1'b1;
                f_mfa = 1'b0;
            end
        end
        f_mfa = 1'b0;
        cur_rdata = ref_read(9'h040, 2'b11);
        m_last_d = 1'b0;
        total++;
        if (!got || f_err !== 1'b0 || rdata !== cur_rdata) begin
            bad++;
            $display("FAIL rm_regrant: got=%b err=%b rdata=%h required 1 0 %h",
                     got, f_err, rdata, cur_rdata);
        end
        @(posedge Clk);
    endtask

    task automatic test_random();
        bit rf, rd, drw;
        logic [8:0] fa, da;
        logic [1:0] fs, ds;
        int sel, r, lat;
        logic [1:0] sz [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            rf = (sel != 1);
            rd = (sel != 0);
            fs = sz[$urandom_range(0, 7)];
            ds = sz[$urandom_range(0, 7)];
            fa = 9'($urandom_range(0, 511));
            da = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) fa = fa & 9'h1fc;
            if ($urandom_range(0, 3) != 0) da = da & 9'h1fc;
            drw = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            lat = (r < 7) ? (r % 3) + 1 : (r == 7 ? 0 : (r == 8 ? TMO : TMO + 1));
            do_round(rf, rd, fa, fs, da, ds, drw, $urandom, lat, i);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16] = 8'h04; mem[17] = 8'h00; mem[18] = 8'h22; mem[19] = 8'h8C;
        for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];
        test_reset();
        test_tie();
        test_fetch_word();
        test_errors();
        test_timeout();
        test_block();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
